// File: rtl/weight_cache_pkg.sv
// Shared types and helpers for the layer weight cache: FSM states, word
// geometry and the matrix-size-to-word-count calculation.
package weight_cache_pkg;

    localparam int DATA_W = 64;
    localparam int LANES  = 8;
    localparam int LANE_W = DATA_W / LANES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CACHED = 2'd2
    } wc_state_e;

    // Words per layer = row * col / 8, clipped to the cache depth. A zero-sized
    // matrix is treated as one word so the loader can never wait forever.
    function automatic logic [31:0] calc_words(
        input logic [31:0] row,
        input logic [31:0] col,
        input logic [31:0] depth
    );
        logic [31:0] prod;
        logic [31:0] words;
        prod  = row * col;
        words = {3'b000, prod[31:3]};
        if (words > depth) begin
            calc_words = depth;
        end else if (words == 32'd0) begin
            calc_words = 32'd1;
        end else begin
            calc_words = words;
        end
    endfunction

endpackage

// File: rtl/weight_ram_sdp.sv
// Simple dual-port weight RAM: one write port, one registered read port whose
// output register holds between reads and clears on reset.
module weight_ram_sdp #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port with synchronous output clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/weight_cache_buffer.sv
// Layer weight cache: loads one weight matrix from the stream, then replays it
// one 64-bit word per read request to the 8-column systolic tile until LayerEnd.
module weight_cache_buffer #(
    parameter int DATA_W = weight_cache_pkg::DATA_W,
    parameter int DEPTH  = 4096,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sData_valid,
    output logic              sData_ready,
    input  logic [DATA_W-1:0] sData_payload,
    input  logic [DIM_W-1:0]  Matrix_Row,
    input  logic [DIM_W-1:0]  Matrix_Col,
    input  logic              Raddr_Valid,
    input  logic              LayerEnd,
    output logic              Weight_Cached,
    output logic              mValid,
    output logic [7:0]        mData_0,
    output logic [7:0]        mData_1,
    output logic [7:0]        mData_2,
    output logic [7:0]        mData_3,
    output logic [7:0]        mData_4,
    output logic [7:0]        mData_5,
    output logic [7:0]        mData_6,
    output logic [7:0]        mData_7
);

    import weight_cache_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    wc_state_e         state_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [ADDR_W-1:0] raddr_r;
    logic [ADDR_W-1:0] n_last_r;
    logic              ready_r;
    logic              cached_r;
    logic              mvalid_r;
    logic [31:0]       words_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [DATA_W-1:0] rd_data_s;

    assign words_s = calc_words(32'(Matrix_Row), 32'(Matrix_Col), 32'(DEPTH));
    assign wr_en_s = (state_r == LOAD) && sData_valid && ready_r;
    assign rd_en_s = (state_r == CACHED) && Raddr_Valid;

    // Layer control: state, write/read pointers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            waddr_r  <= ADDR_ZERO;
            raddr_r  <= ADDR_ZERO;
            n_last_r <= ADDR_ZERO;
            ready_r  <= 1'b0;
            cached_r <= 1'b0;
            mvalid_r <= 1'b0;
        end else begin
            mvalid_r <= rd_en_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= LOAD;
                        waddr_r  <= ADDR_ZERO;
                        n_last_r <= ADDR_W'(words_s - 32'd1);
                        ready_r  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr_en_s) begin
                        waddr_r <= waddr_r + ADDR_ONE;
                        // Dropping ready here keeps any extra valid words unaccepted.
                        if (waddr_r == n_last_r) begin
                            state_r  <= CACHED;
                            ready_r  <= 1'b0;
                            cached_r <= 1'b1;
                            raddr_r  <= ADDR_ZERO;
                        end
                    end
                end
                CACHED: begin
                    if (rd_en_s) begin
                        raddr_r <= (raddr_r == n_last_r) ? ADDR_ZERO : raddr_r + ADDR_ONE;
                    end
                    if (LayerEnd) begin
                        state_r  <= IDLE;
                        cached_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ready_r  <= 1'b0;
                    cached_r <= 1'b0;
                end
            endcase
        end
    end

    weight_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (waddr_r),
        .wr_data (sData_payload),
        .rd_en   (rd_en_s),
        .rd_addr (raddr_r),
        .rd_data (rd_data_s)
    );

    assign sData_ready   = ready_r;
    assign Weight_Cached = cached_r;
    assign mValid        = mvalid_r;
    assign mData_0       = rd_data_s[7:0];
    assign mData_1       = rd_data_s[15:8];
    assign mData_2       = rd_data_s[23:16];
    assign mData_3       = rd_data_s[31:24];
    assign mData_4       = rd_data_s[39:32];
    assign mData_5       = rd_data_s[47:40];
    assign mData_6       = rd_data_s[55:48];
    assign mData_7       = rd_data_s[63:56];

endmodule

// File: tb/tb_weight_cache_buffer.sv
// Self-checking bench for weight_cache_buffer: table of layer shapes with an
// array-based cache model, plus hand-written reset and interference sequences.
module tb_weight_cache_buffer;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sData_valid;
    logic        sData_ready;
    logic [63:0] sData_payload;
    logic [15:0] Matrix_Row;
    logic [15:0] Matrix_Col;
    logic        Raddr_Valid;
    logic        LayerEnd;
    logic        Weight_Cached;
    logic        mValid;
    logic [7:0]  mData_0, mData_1, mData_2, mData_3;
    logic [7:0]  mData_4, mData_5, mData_6, mData_7;
    logic [63:0] mdata_w;

    weight_cache_buffer #(.DATA_W(64), .DEPTH(DEPTH), .DIM_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .sData_valid   (sData_valid),
        .sData_ready   (sData_ready),
        .sData_payload (sData_payload),
        .Matrix_Row    (Matrix_Row),
        .Matrix_Col    (Matrix_Col),
        .Raddr_Valid   (Raddr_Valid),
        .LayerEnd      (LayerEnd),
        .Weight_Cached (Weight_Cached),
        .mValid        (mValid),
        .mData_0       (mData_0),
        .mData_1       (mData_1),
        .mData_2       (mData_2),
        .mData_3       (mData_3),
        .mData_4       (mData_4),
        .mData_5       (mData_5),
        .mData_6       (mData_6),
        .mData_7       (mData_7)
    );

    assign mdata_w = {mData_7, mData_6, mData_5, mData_4, mData_3, mData_2, mData_1, mData_0};

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] model_mem [DEPTH];
    int          model_n = 1;
    int          exp_rptr = 0;
    logic [63:0] last_mdata = 64'd0;

    typedef struct {
        int row;
        int col;
        int exp_n;
        int on;
        int off;
        bit incr;
        bit inject;
        int rd_cycles;
        bit rd_held;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_layer(input int row, input int col);
        Matrix_Row = 16'(row);
        Matrix_Col = 16'(col);
        start      = 1'b1;
        tick();
        start = 1'b0;
        check_bit("ready_after_start", sData_ready, 1'b1);
        check_bit("cached_low_in_load", Weight_Cached, 1'b0);
    endtask

    // Streams words until stop_at beats are accepted; beats counted from valid&ready.
    task automatic load_words(input int exp_n, input int stop_at, input int on, input int off,
                              input bit incr, input bit inject);
        int          beats = 0;
        int          cyc = 0;
        int          limit;
        int          bad_mvalid = 0;
        int          bad_cached = 0;
        int          extra = 0;
        bit          acc;
        bit          injected = 1'b0;
        logic [63:0] w;
        logic [15:0] row_save;
        logic [15:0] col_save;
        row_save = Matrix_Row;
        col_save = Matrix_Col;
        limit    = exp_n * 16 + 2000;
        while (beats < stop_at && cyc < limit) begin
            sData_valid   = ((cyc % (on + off)) < on);
            w             = incr ? 64'(beats) : {$urandom, $urandom};
            sData_payload = sData_valid ? w : {$urandom, $urandom};
            Raddr_Valid   = 1'($urandom_range(0, 1));
            if (inject && beats == 5 && !injected) begin
                start      = 1'b1;
                LayerEnd   = 1'b1;
                Matrix_Row = 16'd1;
                Matrix_Col = 16'd8;
                injected   = 1'b1;
            end
            acc = sData_valid && sData_ready;
            tick();
            start      = 1'b0;
            LayerEnd   = 1'b0;
            Matrix_Row = row_save;
            Matrix_Col = col_save;
            if (acc) begin
                model_mem[beats] = w;
                beats++;
            end
            if (mValid) bad_mvalid++;
            if (Weight_Cached && beats < exp_n) bad_cached++;
            cyc++;
        end
        Raddr_Valid = 1'b0;
        check_int("load_beats", beats, stop_at);
        check_int("mvalid_during_load", bad_mvalid, 0);
        check_int("cached_early", bad_cached, 0);
        if (stop_at == exp_n) begin
            check_bit("ready_drop_after_last", sData_ready, 1'b0);
            check_bit("cached_after_last", Weight_Cached, 1'b1);
            for (int i = 0; i < 4; i++) begin
                sData_valid   = 1'b1;
                sData_payload = {$urandom, $urandom};
                if (sData_ready) extra++;
                tick();
            end
            check_int("extra_beats_accepted", extra, 0);
            model_n  = exp_n;
            exp_rptr = 0;
        end
        sData_valid = 1'b0;
    endtask

    task automatic read_phase(input int cycles, input bit held);
        logic rv;
        for (int i = 0; i < cycles; i++) begin
            rv          = held ? 1'b1 : 1'($urandom_range(0, 1));
            Raddr_Valid = rv;
            tick();
            check_bit("mvalid", mValid, rv);
            if (rv) begin
                check_word("mdata", mdata_w, model_mem[exp_rptr]);
                last_mdata = model_mem[exp_rptr];
                exp_rptr   = (exp_rptr + 1) % model_n;
            end else begin
                check_word("mdata_hold", mdata_w, last_mdata);
            end
        end
        Raddr_Valid = 1'b0;
    endtask

    task automatic end_layer();
        LayerEnd = 1'b1;
        tick();
        LayerEnd = 1'b0;
        check_bit("cached_after_layerend", Weight_Cached, 1'b0);
        Raddr_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("mvalid_idle", mValid, 1'b0);
            check_word("mdata_idle_hold", mdata_w, last_mdata);
        end
        Raddr_Valid = 1'b0;
        check_bit("ready_idle", sData_ready, 1'b0);
    endtask

    initial begin
        vecs[0] = '{row: 512, col: 32,   exp_n: 2048, on: 1,  off: 0,   incr: 1'b1, inject: 1'b0, rd_cycles: 4100, rd_held: 1'b1};
        vecs[1] = '{row: 16,  col: 8,    exp_n: 16,   on: 64, off: 448, incr: 1'b0, inject: 1'b0, rd_cycles: 40,   rd_held: 1'b0};
        vecs[2] = '{row: 16,  col: 8,    exp_n: 16,   on: 8,  off: 448, incr: 1'b0, inject: 1'b0, rd_cycles: 40,   rd_held: 1'b0};
        vecs[3] = '{row: 8,   col: 16,   exp_n: 16,   on: 1,  off: 0,   incr: 1'b0, inject: 1'b1, rd_cycles: 40,   rd_held: 1'b0};
        vecs[4] = '{row: 1,   col: 8,    exp_n: 1,    on: 1,  off: 0,   incr: 1'b0, inject: 1'b0, rd_cycles: 10,   rd_held: 1'b0};
        vecs[5] = '{row: 64,  col: 1024, exp_n: 4096, on: 1,  off: 0,   incr: 1'b0, inject: 1'b0, rd_cycles: 4100, rd_held: 1'b1};
        vecs[6] = '{row: 3,   col: 24,   exp_n: 9,    on: 2,  off: 1,   incr: 1'b0, inject: 1'b0, rd_cycles: 30,   rd_held: 1'b0};

        reset         = 1'b1;
        start         = 1'b0;
        sData_valid   = 1'b0;
        sData_payload = 64'd0;
        Matrix_Row    = 16'd0;
        Matrix_Col    = 16'd0;
        Raddr_Valid   = 1'b0;
        LayerEnd      = 1'b0;
        tick();
        tick();
        check_bit("reset_ready", sData_ready, 1'b0);
        check_bit("reset_cached", Weight_Cached, 1'b0);
        check_bit("reset_mvalid", mValid, 1'b0);
        check_word("reset_mdata", mdata_w, 64'd0);
        reset = 1'b0;
        tick();

        // Read requests and LayerEnd while idle must do nothing.
        Raddr_Valid = 1'b1;
        LayerEnd    = 1'b1;
        tick();
        Raddr_Valid = 1'b0;
        LayerEnd    = 1'b0;
        check_bit("idle_read_ignored", mValid, 1'b0);
        tick();

        for (int v = 0; v < 7; v++) begin
            start_layer(vecs[v].row, vecs[v].col);
            load_words(vecs[v].exp_n, vecs[v].exp_n, vecs[v].on, vecs[v].off,
                       vecs[v].incr, vecs[v].inject);
            read_phase(vecs[v].rd_cycles, vecs[v].rd_held);
            end_layer();
        end

        // Reset in the middle of a load, then a fresh load from address 0.
        start_layer(512, 32);
        load_words(2048, 100, 1, 0, 1'b1, 1'b0);
        sData_valid = 1'b0;
        reset       = 1'b1;
        tick();
        check_bit("midload_reset_ready", sData_ready, 1'b0);
        check_bit("midload_reset_cached", Weight_Cached, 1'b0);
        check_bit("midload_reset_mvalid", mValid, 1'b0);
        check_word("midload_reset_mdata", mdata_w, 64'd0);
        reset      = 1'b0;
        last_mdata = 64'd0;
        tick();
        start_layer(16, 8);
        load_words(16, 16, 1, 0, 1'b0, 1'b0);
        read_phase(40, 1'b0);
        end_layer();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
